// File: rtl/floor_scheduler.sv
// floor_scheduler
//   Collective (SCAN-style) call scheduler for a 3-floor car.
//   Latches car/hall call pulses into a request register. Chooses the travel
//   direction and drives registered motor commands. Times the door dwell at
//   every serviced floor.
//
//   Ports
//     clk        system clock, all state changes on the rising edge
//     rst_n      asynchronous reset, active HIGH despite the name
//     story      current floor 1..3; 0 (or 4..7) means between floors
//     call_in    car-call pulses, bit0 = floor 1 .. bit2 = floor 3
//     call_up    hall-up pulses, bit0 = floor 1, bit1 = floor 2
//     call_dn    hall-down pulses, bit0 = floor 2, bit1 = floor 3
//     turn_up    motor up command (registered)
//     turn_down  motor down command (registered)
//     door_open  door open (registered)
//     dir_up     committed direction, 1 = up
//     req_lamp   latched requests {call_dn[1:0], call_up[1:0], call_in[2:0]}
//     fault      travel-timeout fault
//
//   Optional feature macro: TRAVEL_TIMEOUT_EN
//     When defined, a stall counter runs while the car should be moving
//     (SEEK / MOVE_UP / MOVE_DOWN). It restarts on every change of story.
//     Reaching TIMEOUT_CYCLES locks the block in FAULT until reset.
//     When undefined, fault is tied to 0.
module floor_scheduler #(
    parameter int unsigned DOOR_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] story,
    input  logic [2:0] call_in,
    input  logic [1:0] call_up,
    input  logic [1:0] call_dn,
    output logic       turn_up,
    output logic       turn_down,
    output logic       door_open,
    output logic       dir_up,
    output logic [6:0] req_lamp,
    output logic       fault
);
    localparam int DW = $clog2(DOOR_CYCLES);

`ifdef TRAVEL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {SEEK, IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT} state_t;
`else
    typedef enum logic [2:0] {SEEK, IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
`endif

    state_t          state_q, state_d;
    logic [6:0]      req_q, req_d;
    logic            dir_q, dir_d;
    logic [DW-1:0]   door_cnt_q, door_cnt_d;
    logic            turn_up_q, turn_up_d;
    logic            turn_down_q, turn_down_d;
    logic            door_open_q, door_open_d;

    // Position decode: illegal sensor codes are treated as "between floors".
    logic [1:0] floor_now;
    logic [2:0] at_f;
    assign floor_now = (story >= 3'd1 && story <= 3'd3) ? story[1:0] : 2'd0;
    assign at_f      = (floor_now == 2'd0) ? 3'b000 : (3'b001 << (floor_now - 2'd1));

    // Decisions see this cycle's pulses, so a call acts on the same edge
    // that lights its lamp.
    logic [6:0] req_eff;
    assign req_eff = req_q | {call_dn, call_up, call_in};

    // Per-floor views of the request set (index 0 = floor 1).
    logic [2:0] car_f, up_f, dn_f, fr;
    for (genvar gi = 0; gi < 3; gi++) begin : g_floor
        assign car_f[gi] = req_eff[gi];
        if (gi < 2) begin : g_up
            assign up_f[gi] = req_eff[3 + gi];
        end else begin : g_no_up
            assign up_f[gi] = 1'b0;
        end
        if (gi > 0) begin : g_dn
            assign dn_f[gi] = req_eff[4 + gi];
        end else begin : g_no_dn
            assign dn_f[gi] = 1'b0;
        end
        assign fr[gi] = car_f[gi] | up_f[gi] | dn_f[gi];
    end

    logic [2:0] above_mask, below_mask;
    logic       above_any, below_any, beyond;
    logic       car_here, up_here, dn_here, dir_hall, opp_hall;
    logic       serviceable, flip, clear_up, clear_dn;
    logic [6:0] svc_clear;

    assign above_mask  = ~(at_f | (at_f - 3'd1));
    assign below_mask  = at_f - 3'd1;
    assign above_any   = |(fr & above_mask);
    assign below_any   = |(fr & below_mask);
    assign beyond      = dir_q ? above_any : below_any;
    assign car_here    = |(car_f & at_f);
    assign up_here     = |(up_f & at_f);
    assign dn_here     = |(dn_f & at_f);
    assign dir_hall    = dir_q ? up_here : dn_here;
    assign opp_hall    = dir_q ? dn_here : up_here;
    assign serviceable = car_here | dir_hall | (opp_hall & ~beyond);
    // Answering the opposite hall call means the car turns around here:
    // the direction flips and that hall call is the one cleared.
    assign flip        = opp_hall & ~dir_hall & ~beyond;
    assign clear_up    = dir_q | flip;
    assign clear_dn    = ~dir_q | flip;
    assign svc_clear   = {clear_dn ? at_f[2:1] : 2'b00,
                          clear_up ? at_f[1:0] : 2'b00,
                          at_f};

    logic tmo_hit;
    logic take_service;

`ifdef TRAVEL_TIMEOUT_EN
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    story_prev_q, story_prev_d;
    logic          fault_q, fault_d;

    always_comb begin
        tmo_d        = '0;
        story_prev_d = floor_now;
        tmo_hit      = 1'b0;
        if (state_q == SEEK || state_q == MOVE_UP || state_q == MOVE_DOWN) begin
            if (floor_now != story_prev_q) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_eff;
        dir_d        = dir_q;
        door_cnt_d   = door_cnt_q;
        take_service = 1'b0;
        case (state_q)
            SEEK: begin
                if (floor_now != 2'd0) state_d = IDLE;
            end
            IDLE: begin
                if (floor_now == 2'd0) begin
                    state_d = SEEK;
                end else if (serviceable) begin
                    take_service = 1'b1;
                end else if (above_any && below_any) begin
                    state_d = dir_q ? MOVE_UP : MOVE_DOWN;
                end else if (above_any) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                end else if (below_any) begin
                    state_d = MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (serviceable)              take_service = 1'b1;
                else if (floor_now == 2'd3)   state_d = IDLE;
            end
            MOVE_DOWN: begin
                if (serviceable)              take_service = 1'b1;
                else if (floor_now == 2'd1)   state_d = IDLE;
            end
            DOOR: begin
                if (serviceable)                  take_service = 1'b1;
                else if (door_cnt_q == '0)        state_d = IDLE;
                else                              door_cnt_d = door_cnt_q - DW'(1);
            end
`ifdef TRAVEL_TIMEOUT_EN
            FAULT: begin
                req_d = req_q;
            end
`endif
            default: state_d = SEEK;
        endcase

        if (take_service) begin
            state_d    = DOOR;
            req_d      = req_eff & ~svc_clear;
            door_cnt_d = DW'(DOOR_CYCLES - 1);
            if (flip) dir_d = ~dir_q;
        end

`ifdef TRAVEL_TIMEOUT_EN
        if (tmo_hit) begin
            state_d    = FAULT;
            req_d      = req_eff;
            dir_d      = dir_q;
            door_cnt_d = door_cnt_q;
        end
`endif
    end

    // Outputs follow the next state, so the turn command drops on the same
    // edge the car is told to stop, and the three are mutually exclusive.
    assign turn_up_d   = (state_d == MOVE_UP);
    assign turn_down_d = (state_d == MOVE_DOWN) || (state_d == SEEK);
    assign door_open_d = (state_d == DOOR);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEEK;
            req_q       <= '0;
            dir_q       <= 1'b0;
            door_cnt_q  <= '0;
            turn_up_q   <= 1'b0;
            turn_down_q <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            dir_q       <= dir_d;
            door_cnt_q  <= door_cnt_d;
            turn_up_q   <= turn_up_d;
            turn_down_q <= turn_down_d;
            door_open_q <= door_open_d;
        end
    end

`ifdef TRAVEL_TIMEOUT_EN
    assign fault_d = (state_d == FAULT);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmo_q        <= '0;
            story_prev_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            story_prev_q <= story_prev_d;
            fault_q      <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign turn_up   = turn_up_q;
    assign turn_down = turn_down_q;
    assign door_open = door_open_q;
    assign dir_up    = dir_q;
    assign req_lamp  = req_q;

endmodule
